// File: rtl/coef_loader.sv
// -----------------------------------------------------------------------------
// coef_loader
//
// Builds a set of NUM_COEF signed coefficients from a narrow pin bus and hands
// each finished set to the watchdog calculation core.
//
// Chunks arrive MSB-first, LOAD_CHUNKS chunks of PIN_W bits per coefficient.
// They collect in a shadow bank. When the core is idle, the shadow bank is
// extended to COEF_W and committed to the active bank. A level start request
// is then raised and held until the core reports busy. Because the bank is
// double buffered, the next set can load while the core is still running.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      PIN_W chunk on the pins
//   in_valid     chunk strobe, accepted when in_valid && in_ready
//   in_ready     shadow bank can take a chunk (shadow not full)
//   load_clr     synchronous abort of a partial or complete shadow load
//   core_busy    core running (level)
//   coef         active bank, coefficient i at [i*COEF_W +: COEF_W]
//   start_calc   level start request, held until core_busy is seen
//   set_pending  a complete set is waiting in the shadow bank
//   overrun      sticky, a strobe arrived while in_ready was low
// -----------------------------------------------------------------------------
module coef_loader #(
    parameter int NUM_COEF    = 2,
    parameter int COEF_W      = 32,
    parameter int PIN_W       = 8,
    parameter int LOAD_CHUNKS = 1,
    parameter int SIGN_EXT    = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PIN_W-1:0]                  in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              load_clr,
    input  logic                              core_busy,
    output logic signed [NUM_COEF*COEF_W-1:0] coef,
    output logic                              start_calc,
    output logic                              set_pending,
    output logic                              overrun
);

    localparam int LOAD_W   = LOAD_CHUNKS * PIN_W;
    localparam int CHUNK_CW = (LOAD_CHUNKS > 1) ? $clog2(LOAD_CHUNKS) : 1;
    localparam int COEF_CW  = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                start_d;
    logic                commit;

    logic [LOAD_W-1:0]   shadow [NUM_COEF];
    logic                shadow_full;
    logic [CHUNK_CW-1:0] chunk_idx;
    logic [COEF_CW-1:0]  coef_idx;
    logic                accept;
    logic                chunk_last;
    logic                coef_last;

    // Shift one chunk into the LSBs of a partially built value. A shift by the
    // full width yields zero, so a single-chunk load simply takes the chunk.
    function automatic logic [LOAD_W-1:0] shift_chunk(input logic [LOAD_W-1:0] prev,
                                                      input logic [PIN_W-1:0]  chunk);
        logic [LOAD_W-1:0] t;
        t             = prev << PIN_W;
        t[PIN_W-1:0]  = chunk;
        return t;
    endfunction

    // Widen a loaded value to the output coefficient width.
    function automatic logic signed [COEF_W-1:0] extend(input logic [LOAD_W-1:0] v);
        logic signed [LOAD_W-1:0] sv;
        sv = signed'(v);
        if (SIGN_EXT != 0) begin
            return COEF_W'(sv);
        end else begin
            return signed'(COEF_W'(v));
        end
    endfunction

    assign in_ready    = !shadow_full;
    assign set_pending = shadow_full;
    assign accept      = in_valid && in_ready;
    assign chunk_last  = (chunk_idx == CHUNK_CW'(LOAD_CHUNKS - 1));
    assign coef_last   = (coef_idx == COEF_CW'(NUM_COEF - 1));

    // Load path: counters, shadow bank, full flag, overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_idx   <= '0;
            coef_idx    <= '0;
            shadow_full <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow[i] <= '0;
            end
        end else if (load_clr) begin
            // Abort wins over any accept or commit in the same cycle.
            chunk_idx   <= '0;
            coef_idx    <= '0;
            shadow_full <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
            if (commit) begin
                shadow_full <= 1'b0;
            end
            // The commit needs shadow_full=1, and accept needs shadow_full=0,
            // so the two never happen in the same cycle.
            if (accept) begin
                shadow[coef_idx] <= shift_chunk(shadow[coef_idx], in_data);
                if (chunk_last) begin
                    chunk_idx <= '0;
                    if (coef_last) begin
                        coef_idx    <= '0;
                        shadow_full <= 1'b1;
                    end else begin
                        coef_idx <= coef_idx + COEF_CW'(1);
                    end
                end else begin
                    chunk_idx <= chunk_idx + CHUNK_CW'(1);
                end
            end
        end
    end

    // Handshake FSM with the core: state register, start request, active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_calc <= 1'b0;
            coef       <= '0;
        end else begin
            state_q    <= state_d;
            start_calc <= start_d;
            if (commit) begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    coef[i*COEF_W +: COEF_W] <= extend(shadow[i]);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (shadow_full && !core_busy && !load_clr) begin
                    commit  = 1'b1;
                    start_d = 1'b1;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                start_d = 1'b1;
                if (core_busy) begin
                    start_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!core_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Parametrised successor to the two-coefficient pin loader. Assembles NUM_COEF signed coefficients from a narrow pin bus, one PIN_W chunk per strobe, into a shadow bank.
- Commits the shadow bank to the active bank and issues a level start request to the calculation core when the core is idle.
- Double buffering lets the next coefficient set load while the core is running.
- Sits between the chip input pins and the watchdog calculation core.

Parameters:
- NUM_COEF, 2, number of coefficients per set (>=1).
- COEF_W, 32, width of each signed output coefficient.
- PIN_W, 8, width of the input pin bus.
- LOAD_CHUNKS, 1, PIN_W chunks per coefficient. LOAD_W = LOAD_CHUNKS*PIN_W, with LOAD_W <= COEF_W.
- SIGN_EXT, 0, extension mode: 0 = zero-extend LOAD_W to COEF_W; 1 = sign-extend from bit LOAD_W-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  PIN_W  chunk on the pins.
- in_valid  in  1  chunk strobe; accepted when in_valid && in_ready.
- in_ready  out  1  = !shadow_full.
- load_clr  in  1  synchronous abort of a partial or complete shadow load.
- core_busy  in  1  core running (level).
- coef  out  NUM_COEF*COEF_W  active bank, signed; coefficient i at bits [i*COEF_W +: COEF_W].
- start_calc  out  1  level start request to the core.
- set_pending  out  1  = shadow_full.
- overrun  out  1  sticky: strobe arrived while in_ready=0.

Behaviour:
- Reset: coef=0, start_calc=0, set_pending=0, overrun=0, in_ready=1. Chunk and coefficient counters = 0. Shadow bank = 0. FSM = S_IDLE.
- Load path:
  - Chunks arrive MSB-first. Each accepted chunk shifts into shadow[coef_idx] as {prev[LOAD_W-PIN_W-1:0], in_data}.
  - chunk_idx wraps at LOAD_CHUNKS and then increments coef_idx.
  - On the accept of chunk NUM_COEF*LOAD_CHUNKS, shadow_full is set and both counters go to 0.
  - Extension (SIGN_EXT) is applied when the shadow value is copied into the active bank.
- Strobe while in_ready=0: chunk dropped, overrun set, no state change.
- load_clr: clears counters, shadow_full and overrun.
  - load_clr has priority over a same-cycle accept and over a same-cycle commit.
  - It never alters coef, start_calc or the FSM.
- FSM:
  - S_IDLE: if shadow_full && !core_busy && !load_clr, then on that edge coef <= extended shadow, shadow_full <= 0, start_calc <= 1, go to S_WAIT_ACK.
  - S_WAIT_ACK: start_calc held at 1. When core_busy=1, start_calc <= 0 and go to S_RUN.
  - S_RUN: when core_busy=0, go to S_IDLE.
  - Illegal state: go to S_IDLE with start_calc <= 0.
- Latency: last chunk accepted at edge k. set_pending=1 after k. With the core idle, coef is updated and start_calc rises after edge k+1.
  - The minimum set-to-set restart gap therefore covers both the core's busy period and one S_IDLE cycle.
- Loading during S_WAIT_ACK/S_RUN fills the shadow bank and never disturbs coef.
- A full shadow waits in S_IDLE until core_busy=0.
- core_busy=1 in S_IDLE with shadow_full=1: no commit; wait.
- Commit edge: in_ready is already 0, so no accept and commit can collide.
- Reset mid-load or mid-run returns to the reset state immediately; any partial set is lost.
- Counter widths: $clog2 of the bound, minimum 1 bit.

Test Plan:
1. Defaults, core_busy=0. Chunks 0x12, 0x85. Then: set_pending=1 for one cycle; coef={32'h00000085, 32'h00000012}; start_calc rises 2 cycles after the 0x85 strobe. Drive core_busy=1 the next cycle -> start_calc=0.
2. LOAD_CHUNKS=2, SIGN_EXT=1. Chunks 0xFF,0x9C, 0x00,0x64. Then: coef0=32'hFFFFFF9C (-100), coef1=32'h00000064 (100).
3. Double buffer: set A commits, core_busy=1. Load set B (0x01, 0x02). Then: coef still A, set_pending=1, in_ready=0. Drop core_busy -> B commits one cycle later with a new start_calc.
4. Overrun: with shadow full, strobe 0x55. Then: overrun=1, shadow unchanged. load_clr -> overrun=0, in_ready=1, counters 0.
5. Abort: one chunk of a 2-coefficient set, then load_clr, then a full set 0x03, 0x04. Then: coef={4, 3}; the stale chunk is absent.
6. Reset asserted while in S_WAIT_ACK with a partial shadow. Then: all outputs at reset values asynchronously. After release, a fresh load behaves as in scenario 1.
